// File: rtl/bol_line_buffer_if.sv
// ============================================================================
// bol_line_buffer_if
// ----------------------------------------------------------------------------
// Purpose:
//   Bundles every non-clock signal of the bolometer ping-pong line buffer.
//   The scan counter and ADC drive the capture side, and the MCU reader drives
//   the readout side. The line buffer consumes both as the slave.
//
// Signal summary (direction seen from the line buffer, i.e. the slave):
//   horizontal  in   10     current pixel column from the scan counter
//   vertical    in   10     current line number from the scan counter
//   change      in   1      line toggle, every transition ends a line
//   adcData     in   WIDTH  pixel sample
//   adcValid    in   1      adcData valid this cycle
//   rdAddr      in   10     reader pixel address
//   lineAck     in   1      reader releases the presented line (pulse)
//   ovrClr      in   1      clears overrun flag and overrun counter
//   rdData      out  WIDTH  sample at rdAddr of the presented bank
//   lineReady   out  1      a completed line is presented
//   lineNum     out  10     line number of the presented line
//   lineIrq     out  1      one-cycle pulse per accepted line
//   overrun     out  1      sticky, a completed line was discarded
//   ovfCnt      out  8      discarded-line counter (zero when not built in)
//
// Modports:
//   master  capture/readout side (scan counter, ADC, MCU reader)
//   slave   the line buffer itself
// ============================================================================
interface bol_line_buffer_if #(
    parameter int WIDTH = 16
);

    logic [9:0]       horizontal;
    logic [9:0]       vertical;
    logic             change;
    logic [WIDTH-1:0] adcData;
    logic             adcValid;
    logic [9:0]       rdAddr;
    logic             lineAck;
    logic             ovrClr;
    logic [WIDTH-1:0] rdData;
    logic             lineReady;
    logic [9:0]       lineNum;
    logic             lineIrq;
    logic             overrun;
    logic [7:0]       ovfCnt;

    // The master side drives the scan position, samples and reader controls,
    // and observes everything the buffer reports back.
    modport master (
        output horizontal,
        output vertical,
        output change,
        output adcData,
        output adcValid,
        output rdAddr,
        output lineAck,
        output ovrClr,
        input  rdData,
        input  lineReady,
        input  lineNum,
        input  lineIrq,
        input  overrun,
        input  ovfCnt
    );

    // The slave side is the line buffer, the mirror image of the master.
    modport slave (
        input  horizontal,
        input  vertical,
        input  change,
        input  adcData,
        input  adcValid,
        input  rdAddr,
        input  lineAck,
        input  ovrClr,
        output rdData,
        output lineReady,
        output lineNum,
        output lineIrq,
        output overrun,
        output ovfCnt
    );

endinterface

// File: rtl/bol_line_buffer.sv
// ============================================================================
// bol_line_buffer
// ----------------------------------------------------------------------------
// Purpose:
//   Ping-pong line buffer between the bolometer scan counter / ADC and the
//   MCU reader. Samples are written into the fill bank at the column given by
//   the scan counter. Each transition of the line toggle closes the line. If
//   the other (read) bank is free, the filled bank is handed to the reader and
//   the banks swap. Otherwise the line is dropped, the fill bank is reused for
//   the next line, and an overrun is flagged.
//
// Parameters:
//   WIDTH  ADC sample width in bits (default 16)
//   DEPTH  pixels per line, at most 1024 (default 640)
//
// Ports:
//   clk    in   system clock, all logic on the rising edge
//   rst    in   asynchronous active-high reset
//   bus    bol_line_buffer_if.slave, carries the capture stream, the reader
//          controls and all status/data outputs
//
// Optional feature:
//   LINE_BUF_OVF_CNT_EN  when defined, bus.ovfCnt is an 8-bit saturating
//                        count of discarded lines. When undefined it is tied
//                        to zero and no counter is built. The overrun flag
//                        behaves the same way in both builds.
//
// Timing summary:
//   - Line completion is registered one cycle after the toggle edge. The bank
//     swap, lineReady and lineIrq follow on the next edge, two cycles after
//     the toggle.
//   - rdData is a registered RAM read, valid one cycle after rdAddr, taken
//     from whichever bank is being presented at that edge.
//   - Reset discards all bank bookkeeping at once. The RAM contents are left
//     as they were.
// ============================================================================
module bol_line_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 640
) (
    input  logic                   clk,
    input  logic                   rst,
    bol_line_buffer_if.slave       bus
);

    // Both banks live in one array: bank 0 occupies the lower DEPTH words and
    // bank 1 the upper DEPTH words. This keeps the storage a single simple
    // dual-port RAM (one write port, one registered read port).
    localparam int MEM_WORDS = 2 * DEPTH;
    localparam int AW        = $clog2(MEM_WORDS);
    localparam logic [10:0] DEPTH_W = 11'(DEPTH);

    // Read-side bookkeeping. Only the bank that is not being filled can ever
    // be full, so one state covers both banks.
    typedef enum logic {
        RD_FREE = 1'b0,
        RD_FULL = 1'b1
    } rdState_t;

    logic [WIDTH-1:0] mem [0:MEM_WORDS-1];

    rdState_t         rdState_q, rdState_d;
    logic             wrBank_q, wrBank_d;
    logic [9:0]       lineNum_q, lineNum_d;
    logic             lineIrq_q, lineIrq_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] rdData_q;

    logic             change_q;
    logic [9:0]       vert_q;
    logic             lineDone_q;
    logic [9:0]       pendNum_q;

    logic             wrEn;
    logic [AW-1:0]    wrIdx;
    logic             rdInRange;
    logic [AW-1:0]    rdIdx;
    logic             ackAccepted;
    logic             overrunEvent;

    // Line-end detection. The toggle and the line number are registered every
    // cycle. A difference between the live toggle and its registered copy
    // means a line just ended. By then the scan counter has already moved on
    // to the next line number, so the completed line's number is the
    // registered copy taken before the toggle. Both the event and that
    // number are captured here and acted on one edge later, which gives the
    // two-cycle toggle-to-ready latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            change_q   <= 1'b0;
            vert_q     <= '0;
            lineDone_q <= 1'b0;
            pendNum_q  <= '0;
        end else begin
            change_q   <= bus.change;
            vert_q     <= bus.vertical;
            lineDone_q <= bus.change ^ change_q;
            pendNum_q  <= vert_q;
        end
    end

    // Write-address generation. Columns at or beyond DEPTH are dropped.
    // Without that guard they would alias into the other bank. Samples that
    // arrive in the two cycles between the toggle and the bank swap still
    // land in the bank that is about to be handed over, so the scan timing
    // is expected to leave those cycles free of valid samples.
    always_comb begin
        wrEn  = bus.adcValid && ({1'b0, bus.horizontal} < DEPTH_W);
        wrIdx = AW'(bus.horizontal);
        if (wrBank_q) begin
            wrIdx = AW'(DEPTH) + AW'(bus.horizontal);
        end
    end

    // Read-address generation always targets the bank opposite the fill bank,
    // that is, the one currently being presented. Out-of-range reader
    // addresses return zero rather than data from the fill bank.
    always_comb begin
        rdInRange = {1'b0, bus.rdAddr} < DEPTH_W;
        rdIdx     = AW'(bus.rdAddr);
        if (!wrBank_q) begin
            rdIdx = AW'(DEPTH) + AW'(bus.rdAddr);
        end
    end

    // RAM write port. It has no reset, so the array stays inferable as block
    // RAM, and a repeated write to the same pixel simply overwrites it.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrIdx] <= bus.adcData;
        end
    end

    // Registered RAM read port. The output register is cleared by reset so
    // the reader sees zero until it issues its first read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdData_q <= '0;
        end else if (rdInRange) begin
            rdData_q <= mem[rdIdx];
        end else begin
            rdData_q <= '0;
        end
    end

    // Bank hand-over decision. An acknowledge only counts while a line is
    // presented. It is applied before a coincident line end, so a reader
    // that acknowledges just in time frees the bank for the new line, which
    // is then accepted without a gap in lineReady. If the read bank is still
    // held, the new line is dropped and the fill bank stays where it is. In
    // the same cycle a clear request loses to a fresh overrun.
    always_comb begin
        rdState_d    = rdState_q;
        wrBank_d     = wrBank_q;
        lineNum_d    = lineNum_q;
        lineIrq_d    = 1'b0;
        overrun_d    = overrun_q;
        overrunEvent = 1'b0;
        ackAccepted  = bus.lineAck && (rdState_q == RD_FULL);

        if (bus.ovrClr) begin
            overrun_d = 1'b0;
        end

        if (lineDone_q) begin
            if ((rdState_q == RD_FREE) || ackAccepted) begin
                rdState_d = RD_FULL;
                wrBank_d  = ~wrBank_q;
                lineNum_d = pendNum_q;
                lineIrq_d = 1'b1;
            end else begin
                overrun_d    = 1'b1;
                overrunEvent = 1'b1;
            end
        end else if (ackAccepted) begin
            rdState_d = RD_FREE;
        end
    end

    // Bank bookkeeping and status registers. All of them drop back to the
    // empty state at once on reset, whatever the scan or reader is doing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdState_q <= RD_FREE;
            wrBank_q  <= 1'b0;
            lineNum_q <= '0;
            lineIrq_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rdState_q <= rdState_d;
            wrBank_q  <= wrBank_d;
            lineNum_q <= lineNum_d;
            lineIrq_q <= lineIrq_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef LINE_BUF_OVF_CNT_EN
    logic [7:0] ovfCnt_q, ovfCnt_d;

    // Discarded-line counter. It saturates at 255 so a stalled reader cannot
    // wrap it back to a small value. A clear that coincides with a new
    // overrun leaves a count of one, because that overrun still happened.
    always_comb begin
        ovfCnt_d = ovfCnt_q;
        if (bus.ovrClr) begin
            ovfCnt_d = '0;
        end
        if (overrunEvent) begin
            if (bus.ovrClr) begin
                ovfCnt_d = 8'd1;
            end else if (ovfCnt_q != 8'hFF) begin
                ovfCnt_d = ovfCnt_q + 8'd1;
            end
        end
    end

    // Counter register, cleared with the rest of the status on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovfCnt_q <= '0;
        end else begin
            ovfCnt_q <= ovfCnt_d;
        end
    end

    assign bus.ovfCnt = ovfCnt_q;
`else
    // Counter not built. The output reads as a constant zero.
    assign bus.ovfCnt = '0;
`endif

    // Every output comes straight from a register, so there is no
    // combinational path from any input to any output.
    assign bus.rdData    = rdData_q;
    assign bus.lineReady = (rdState_q == RD_FULL);
    assign bus.lineNum   = lineNum_q;
    assign bus.lineIrq   = lineIrq_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_bol_line_buffer.sv
// ============================================================================
// tb_bol_line_buffer
// ----------------------------------------------------------------------------
// Directed bench for bol_line_buffer (WIDTH=16, DEPTH=640). Inputs are driven
// 1 time unit after each rising edge, and outputs are checked at that same
// point, so each check sees the state left by the preceding edge. Expected
// overrun counts depend on LINE_BUF_OVF_CNT_EN.
// ============================================================================
module tb_bol_line_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 640;

`ifdef LINE_BUF_OVF_CNT_EN
    localparam logic [7:0] EXP_OVF_TWO = 8'd2;
    localparam logic [7:0] EXP_OVF_ONE = 8'd1;
    localparam logic [7:0] EXP_OVF_SAT = 8'd255;
`else
    localparam logic [7:0] EXP_OVF_TWO = 8'd0;
    localparam logic [7:0] EXP_OVF_ONE = 8'd0;
    localparam logic [7:0] EXP_OVF_SAT = 8'd0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compareCount  = 0;
    int   mismatchCount = 0;

    bol_line_buffer_if #(.WIDTH(WIDTH)) bus ();

    bol_line_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Single comparison point. It counts the comparison and reports any
    // difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges and stop 1 unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One valid sample at the given column, written on the next edge.
    task automatic applyStimulus(input logic [9:0] h, input logic [15:0] d);
        bus.horizontal = h;
        bus.adcData    = d;
        bus.adcValid   = 1'b1;
        tick(1);
        bus.adcValid   = 1'b0;
    endtask

    // Fill a whole line with base + column.
    task automatic fillLine(input logic [9:0] lineNo, input logic [15:0] base);
        bus.vertical = lineNo;
        for (int h = 0; h < DEPTH; h++) begin
            applyStimulus(10'(h), base + 16'(h));
        end
        bus.horizontal = '0;
    endtask

    // Toggle the line flag and advance the line number together, as the scan
    // counter does. Returns one edge after the toggle is sampled.
    task automatic endLine(input logic [9:0] nextLine);
        bus.change     = ~bus.change;
        bus.vertical   = nextLine;
        bus.horizontal = '0;
        tick(1);
    endtask

    initial begin
        bus.horizontal = '0;
        bus.vertical   = '0;
        bus.change     = 1'b0;
        bus.adcData    = '0;
        bus.adcValid   = 1'b0;
        bus.rdAddr     = '0;
        bus.lineAck    = 1'b0;
        bus.ovrClr     = 1'b0;
        rst            = 1'b1;
        tick(3);

        checkOutput("reset rdData",    32'(bus.rdData),    32'h0);
        checkOutput("reset lineReady", 32'(bus.lineReady), 32'h0);
        checkOutput("reset lineNum",   32'(bus.lineNum),   32'h0);
        checkOutput("reset lineIrq",   32'(bus.lineIrq),   32'h0);
        checkOutput("reset overrun",   32'(bus.overrun),   32'h0);
        checkOutput("reset ovfCnt",    32'(bus.ovfCnt),    32'h0);
        rst = 1'b0;
        tick(2);

        // An acknowledge with nothing presented must be ignored.
        bus.lineAck = 1'b1;
        tick(1);
        bus.lineAck = 1'b0;

        // Line 5, data equal to the pixel index.
        fillLine(10'd5, 16'h0000);
        endLine(10'd6);
        checkOutput("ready not yet", 32'(bus.lineReady), 32'h0);
        tick(1);
        checkOutput("line5 ready",   32'(bus.lineReady), 32'h1);
        checkOutput("line5 num",     32'(bus.lineNum),   32'd5);
        checkOutput("line5 irq",     32'(bus.lineIrq),   32'h1);
        bus.rdAddr = 10'd17;
        tick(1);
        checkOutput("line5 irq end", 32'(bus.lineIrq),   32'h0);
        checkOutput("line5 rd17",    32'(bus.rdData),    32'd17);
        bus.rdAddr = 10'd639;
        tick(1);
        checkOutput("line5 rd639",   32'(bus.rdData),    32'd639);

        // Two more line ends without an acknowledge: both are dropped.
        bus.rdAddr = 10'd17;
        endLine(10'd7);
        tick(3);
        endLine(10'd8);
        tick(3);
        checkOutput("ovr flag",      32'(bus.overrun),   32'h1);
        checkOutput("ovr count2",    32'(bus.ovfCnt),    32'(EXP_OVF_TWO));
        checkOutput("ovr keep num",  32'(bus.lineNum),   32'd5);
        checkOutput("ovr keep rdy",  32'(bus.lineReady), 32'h1);
        checkOutput("ovr keep data", 32'(bus.rdData),    32'd17);
        bus.lineAck = 1'b1;
        tick(1);
        bus.lineAck = 1'b0;
        checkOutput("ack drops rdy", 32'(bus.lineReady), 32'h0);

        // After the acknowledge, the next line is accepted normally.
        fillLine(10'd8, 16'h1000);
        endLine(10'd9);
        tick(1);
        checkOutput("line8 ready",   32'(bus.lineReady), 32'h1);
        checkOutput("line8 num",     32'(bus.lineNum),   32'd8);
        tick(1);
        checkOutput("line8 rd17",    32'(bus.rdData),    32'h1011);
        bus.ovrClr = 1'b1;
        tick(1);
        bus.ovrClr = 1'b0;
        checkOutput("clr overrun",   32'(bus.overrun),   32'h0);
        checkOutput("clr ovfCnt",    32'(bus.ovfCnt),    32'h0);

        // The acknowledge lands in the same cycle as the line end.
        fillLine(10'd9, 16'h2000);
        endLine(10'd10);
        bus.lineAck = 1'b1;
        tick(1);
        bus.lineAck = 1'b0;
        checkOutput("coinc ready",   32'(bus.lineReady), 32'h1);
        checkOutput("coinc num",     32'(bus.lineNum),   32'd9);
        checkOutput("coinc irq",     32'(bus.lineIrq),   32'h1);
        checkOutput("coinc no ovr",  32'(bus.overrun),   32'h0);
        tick(1);
        checkOutput("coinc rd17",    32'(bus.rdData),    32'h2011);

        // Out-of-range columns are dropped. The bank still holds line 8 data.
        bus.lineAck = 1'b1;
        tick(1);
        bus.lineAck  = 1'b0;
        bus.vertical = 10'd10;
        applyStimulus(10'd0,    16'h0A0A);
        applyStimulus(10'd639,  16'hBEEF);
        applyStimulus(10'd640,  16'hDEAD);
        applyStimulus(10'd1023, 16'hDEAD);
        endLine(10'd11);
        tick(1);
        checkOutput("line10 num",    32'(bus.lineNum),   32'd10);
        bus.rdAddr = 10'd639;
        tick(1);
        checkOutput("oob rd639",     32'(bus.rdData),    32'hBEEF);
        bus.rdAddr = 10'd0;
        tick(1);
        checkOutput("oob rd0",       32'(bus.rdData),    32'h0A0A);
        bus.rdAddr = 10'd17;
        tick(1);
        checkOutput("oob rd17",      32'(bus.rdData),    32'h1011);

        // Reset while a line is presented, an overrun is pending and a fill is
        // under way.
        endLine(10'd12);
        tick(1);
        checkOutput("pre-rst ovr",   32'(bus.overrun),   32'h1);
        checkOutput("pre-rst cnt",   32'(bus.ovfCnt),    32'(EXP_OVF_ONE));
        bus.vertical = 10'd12;
        for (int h = 0; h < 10; h++) begin
            applyStimulus(10'(h), 16'h3000 + 16'(h));
        end
        bus.change = 1'b0;
        rst        = 1'b1;
        tick(1);
        checkOutput("rst rdy",       32'(bus.lineReady), 32'h0);
        checkOutput("rst num",       32'(bus.lineNum),   32'h0);
        checkOutput("rst data",      32'(bus.rdData),    32'h0);
        checkOutput("rst ovr",       32'(bus.overrun),   32'h0);
        checkOutput("rst cnt",       32'(bus.ovfCnt),    32'h0);
        rst = 1'b0;
        tick(2);
        fillLine(10'd20, 16'h4000);
        endLine(10'd21);
        tick(1);
        checkOutput("post-rst rdy",  32'(bus.lineReady), 32'h1);
        checkOutput("post-rst num",  32'(bus.lineNum),   32'd20);
        tick(1);
        checkOutput("post-rst rd17", 32'(bus.rdData),    32'h4011);

        // A long overrun burst saturates the counter. A clear then empties it.
        for (int i = 0; i < 300; i++) begin
            endLine(10'(22 + (i % 800)));
        end
        tick(3);
        checkOutput("sat overrun",   32'(bus.overrun),   32'h1);
        checkOutput("sat ovfCnt",    32'(bus.ovfCnt),    32'(EXP_OVF_SAT));
        checkOutput("sat keep num",  32'(bus.lineNum),   32'd20);
        bus.ovrClr = 1'b1;
        tick(1);
        bus.ovrClr = 1'b0;
        checkOutput("sat clr ovr",   32'(bus.overrun),   32'h0);
        checkOutput("sat clr cnt",   32'(bus.ovfCnt),    32'h0);

        // A clear that coincides with a new overrun: the set wins.
        endLine(10'd400);
        bus.ovrClr = 1'b1;
        tick(1);
        bus.ovrClr = 1'b0;
        checkOutput("clr+ovr flag",  32'(bus.overrun),   32'h1);
        checkOutput("clr+ovr cnt",   32'(bus.ovfCnt),    32'(EXP_OVF_ONE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/bol_line_buffer.md
# bol_line_buffer

Ping-pong line buffer that captures bolometer ADC samples into on-chip RAM at the pixel address driven by the scan counter, and hands completed lines to the MCU-side reader. Sits directly downstream of the scan counter (`top_cnt`), consuming its HORIZONTAL, VERTICAL and CHANGE outputs alongside the ADC sample stream. It flags buffer overruns when the reader falls behind.

## Interface
- `WIDTH`, 16: ADC sample width in bits.
- `DEPTH`, 640: pixels per line; must be ≤ 1024.

- `CLK`  in  1  system clock, all logic on rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `HORIZONTAL`  in  10  current pixel column from the scan counter.
- `VERTICAL`  in  10  current line number from the scan counter.
- `CHANGE`  in  1  line toggle; every transition marks end of line.
- `ADC_DATA`  in  WIDTH  pixel sample.
- `ADC_VALID`  in  1  ADC_DATA valid this cycle.
- `RD_ADDR`  in  10  reader pixel address.
- `LINE_ACK`  in  1  reader releases presented line (1-cycle pulse).
- `OVR_CLR`  in  1  clears OVERRUN (and OVF_CNT).
- `RD_DATA`  out  WIDTH  sample at RD_ADDR of presented bank.
- `LINE_READY`  out  1  a completed line is presented.
- `LINE_NUM`  out  10  line number of presented line.
- `LINE_IRQ`  out  1  1-cycle pulse per accepted line.
- `OVERRUN`  out  1  sticky: a completed line was discarded.
- `OVF_CNT`  out  8  overrun counter (see Configuration).

## Operation
- Two banks of DEPTH × WIDTH RAM; `wr_bank` selects the fill bank, the other bank is the read bank.
- Write: when ADC_VALID=1 and HORIZONTAL < DEPTH, store ADC_DATA at [wr_bank][HORIZONTAL]. Writes with HORIZONTAL ≥ DEPTH are dropped. Repeat writes to the same pixel: last one wins.
- End of line: `change_d` registers CHANGE; `line_done` = CHANGE ≠ change_d. `vert_d` registers VERTICAL, and the line number of the completed line is `vert_d` at line_done, since VERTICAL has already advanced.
- On line_done:
  - If the read bank is free (after applying any LINE_ACK in the same cycle): the fill bank becomes FULL with LINE_NUM=vert_d, wr_bank flips, and LINE_IRQ pulses.
  - Otherwise: the line is discarded, wr_bank is unchanged (the next line overwrites it), OVERRUN←1, and the overrun counter increments.
- At most one bank is FULL at a time.
- Readout: LINE_READY=1 while the read bank is FULL. LINE_ACK is ignored while LINE_READY=0. An accepted LINE_ACK frees the bank.
- Same-cycle LINE_ACK and line_done: the ACK is applied first and the new line is accepted. LINE_READY stays 1, and LINE_NUM/RD_DATA switch to the new bank.
- OVR_CLR clears OVERRUN. If an overrun occurs in the same cycle, the set wins.

## Timing
- Reset values:
  - RD_DATA=0, LINE_READY=0, LINE_NUM=0, LINE_IRQ=0, OVERRUN=0, OVF_CNT=0.
  - Both banks free, wr_bank=0.
  - change_d←CHANGE is not sampled; it resets to 0.
- line_done is detected 1 cycle after the CHANGE edge. LINE_READY and LINE_IRQ assert on the following edge, 2 cycles after the CHANGE transition.
- RD_DATA latency is 1 cycle after RD_ADDR, from the currently presented bank. Synchronous read; the RAM is inferable.
- LINE_READY falls 1 cycle after an accepted LINE_ACK. No same-cycle combinational path from inputs to outputs.
- ADC sample at the last pixel of a line: written if ADC_VALID coincides with HORIZONTAL=DEPTH-1, before CHANGE toggles.
- RESET mid-line or mid-readout: all bank state is discarded immediately. RAM contents are undefined and are not cleared.

## Configuration
- `LINE_BUF_OVF_CNT_EN` defined:
  - OVF_CNT is an 8-bit counter, incremented per discarded line and saturating at 255.
  - OVR_CLR zeroes it. If OVR_CLR and an overrun coincide, the result is 1.
- Undefined: OVF_CNT is tied to 0 with no counter logic. OVERRUN behaves identically.

## Test plan
- Reset, then fill line 5 with data = pixel index, toggle CHANGE → 2 cycles later LINE_READY=1, LINE_NUM=5, LINE_IRQ one pulse; RD_ADDR=17 → RD_DATA=17 next cycle.
- Line ready, no ACK, two further CHANGE toggles → OVERRUN=1, OVF_CNT=2 (0 with macro off), LINE_NUM remains 5; ACK → next line accepted normally.
- LINE_ACK in the same cycle as line_done → LINE_READY stays 1, LINE_NUM steps to the new line, OVERRUN stays 0.
- Write with HORIZONTAL=DEPTH (640) → RAM untouched; read of address 639 returns its last valid write.
- Assert RESET while LINE_READY=1 and mid-fill → all outputs 0 next edge; the next completed line is presented in bank 0.
- 300 consecutive overruns with the macro on → OVF_CNT saturates at 255; OVR_CLR → OVERRUN=0, OVF_CNT=0.
